// File: rtl/axi_sample_pkg.sv
// Shared channel codes, filter nibble layout and state encoding for the AXI sample
// capture scheduler.
package axi_sample_pkg;

  localparam int unsigned NUM_CH = 4;

  localparam logic [1:0] CH_WADDR = 2'd0;
  localparam logic [1:0] CH_WDATA = 2'd1;
  localparam logic [1:0] CH_RADDR = 2'd2;
  localparam logic [1:0] CH_RDATA = 2'd3;

  localparam logic [3:0] BASE_WADDR = 4'd15;
  localparam logic [3:0] BASE_WDATA = 4'd11;
  localparam logic [3:0] BASE_RADDR = 4'd7;
  localparam logic [3:0] BASE_RDATA = 4'd3;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StDrain = 2'b10
  } smp_state_e;

  function automatic int unsigned REC_W(int unsigned dw);
    return dw + 4;
  endfunction

  // Bit of the config vector that enables a given channel/selector combination.
  function automatic logic [3:0] conf_idx(logic [1:0] chan, logic [1:0] sel);
    logic [3:0] base;
    case (chan)
      CH_WADDR: base = BASE_WADDR;
      CH_WDATA: base = BASE_WDATA;
      CH_RADDR: base = BASE_RADDR;
      default:  base = BASE_RDATA;
    endcase
    return base - {2'b00, sel};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous capture FIFO; a push into a full FIFO is accepted only alongside a pop.
module sample_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == LW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = cnt_q;
  // Head is forced to zero while empty so the record output is clean out of reset.
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/axi_sample_ctrl.sv
// Capture scheduler: filters AXI4-lite handshakes, holds one hit per channel and
// round-robins the holders into the readout FIFO.
module axi_sample_ctrl
  import axi_sample_pkg::*;
#(
  parameter int unsigned DW           = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CNTW         = 16,
  parameter bit          STOP_ON_FULL = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             sample_conf_ctrl,
  input  logic                    arm,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    awvalid,
  input  logic                    wvalid,
  input  logic                    arvalid,
  input  logic                    rvalid,
  input  logic                    awready,
  input  logic                    wready,
  input  logic                    arready,
  input  logic                    rready,
  input  logic [DW-1:0]           awpayld,
  input  logic [DW-1:0]           wpayld,
  input  logic [DW-1:0]           arpayld,
  input  logic [DW-1:0]           rpayld,
  input  logic [2:0]              awprot,
  input  logic [2:0]              wprot,
  input  logic [2:0]              arprot,
  input  logic [2:0]              rprot,
  output logic                    smp_valid,
  input  logic                    smp_ready,
  output logic [REC_W(DW)-1:0]    smp_rec,
  output logic [1:0]              state,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNTW-1:0]         drop_cnt
);

  localparam int unsigned RW   = REC_W(DW);
  localparam int unsigned SUMW = CNTW + 1;

  logic [NUM_CH-1:0] ch_valid, ch_ready;
  logic [DW-1:0]     ch_payld [NUM_CH];
  logic [2:0]        ch_prot  [NUM_CH];
  logic [1:0]        ch_sel   [NUM_CH];

  smp_state_e        state_q;
  logic [NUM_CH-1:0] hit, drop, grant, hold_vld_q;
  logic [RW-1:0]     hold_rec_q [NUM_CH];
  logic [1:0]        rr_q, grant_idx, arb_idx;
  logic              grant_any, fifo_full, fifo_empty, fifo_room, pop;
  logic [2:0]        drop_n;
  logic [SUMW-1:0]   drop_sum;
  logic [CNTW-1:0]   drop_cnt_q, drop_cnt_d;
  logic              unused_prot;

  assign ch_valid    = {rvalid, arvalid, wvalid, awvalid};
  assign ch_ready    = {rready, arready, wready, awready};
  assign ch_payld[0] = awpayld;
  assign ch_payld[1] = wpayld;
  assign ch_payld[2] = arpayld;
  assign ch_payld[3] = rpayld;
  assign ch_prot[0]  = awprot;
  assign ch_prot[1]  = wprot;
  assign ch_prot[2]  = arprot;
  assign ch_prot[3]  = rprot;
  assign unused_prot = ^{awprot[1], wprot[1], arprot[1], rprot[1]};

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_sel[i] = {ch_prot[i][0], ch_prot[i][2]};
      hit[i]    = ch_valid[i] & ch_ready[i] & (state_q == StRun)
                & sample_conf_ctrl[conf_idx(2'(i), ch_sel[i])];
    end
  end

  assign pop       = smp_valid & smp_ready;
  assign fifo_room = ~fifo_full | pop;

  // First full holder at or after the round-robin pointer wins.
  always_comb begin
    grant     = '0;
    grant_idx = rr_q;
    grant_any = 1'b0;
    arb_idx   = rr_q;
    for (int k = 0; k < NUM_CH; k++) begin
      arb_idx = rr_q + 2'(k);
      if (!grant_any && hold_vld_q[arb_idx]) begin
        grant_any = 1'b1;
        grant_idx = arb_idx;
      end
    end
    if (!fifo_room) grant_any = 1'b0;
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  assign drop = hit & hold_vld_q & ~grant;

  always_comb begin
    drop_n = '0;
    for (int i = 0; i < NUM_CH; i++) drop_n = drop_n + 3'(drop[i]);
    drop_sum   = {1'b0, drop_cnt_q} + SUMW'(drop_n);
    drop_cnt_d = drop_sum[CNTW] ? '1 : drop_sum[CNTW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q    <= StIdle;
      hold_vld_q <= '0;
      rr_q       <= CH_WADDR;
      drop_cnt_q <= '0;
      for (int i = 0; i < NUM_CH; i++) hold_rec_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (hit[i] && (!hold_vld_q[i] || grant[i])) begin
          hold_vld_q[i] <= 1'b1;
          hold_rec_q[i] <= {2'(i), ch_sel[i], ch_payld[i]};
        end else if (grant[i]) begin
          hold_vld_q[i] <= 1'b0;
        end
      end
      if (grant_any) rr_q <= grant_idx + 2'd1;
      drop_cnt_q <= drop_cnt_d;
      unique case (state_q)
        StIdle:  if (arm && !stop) state_q <= StRun;
        StRun:   if (stop || (STOP_ON_FULL && (|drop))) state_q <= StDrain;
        StDrain: if (hold_vld_q == '0) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  sample_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .push  (grant_any),
    .wdata (hold_rec_q[grant_idx]),
    .pop   (pop),
    .rdata (smp_rec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign smp_valid = ~fifo_empty;
  assign state     = state_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_axi_sample_ctrl.sv
// Scoreboard bench for axi_sample_ctrl: expected records are queued as beats are driven
// and checked in order as the readout pops them.
module tb_axi_sample_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample_conf_ctrl;
  logic        arm, stop, clear;
  logic        awvalid, wvalid, arvalid, rvalid;
  logic        awready, wready, arready, rready;
  logic [31:0] awpayld, wpayld, arpayld, rpayld;
  logic [2:0]  awprot, wprot, arprot, rprot;
  logic        smp_valid, smp_ready;
  logic [35:0] smp_rec;
  logic [1:0]  state;
  logic [3:0]  level;
  logic [15:0] drop_cnt;

  logic        sof_smp_valid;
  logic [35:0] sof_smp_rec;
  logic [1:0]  sof_state;
  logic [3:0]  sof_level;
  logic [15:0] sof_drop_cnt;

  int          checks = 0;
  int          failures = 0;
  logic [35:0] sb [$];
  logic [35:0] mon_exp;

  always #5 clk = ~clk;

  axi_sample_ctrl #(.DW(32), .DEPTH(8), .CNTW(16), .STOP_ON_FULL(1'b0)) u_dut (
    .clk(clk), .rst(rst), .sample_conf_ctrl(sample_conf_ctrl),
    .arm(arm), .stop(stop), .clear(clear),
    .awvalid(awvalid), .wvalid(wvalid), .arvalid(arvalid), .rvalid(rvalid),
    .awready(awready), .wready(wready), .arready(arready), .rready(rready),
    .awpayld(awpayld), .wpayld(wpayld), .arpayld(arpayld), .rpayld(rpayld),
    .awprot(awprot), .wprot(wprot), .arprot(arprot), .rprot(rprot),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_rec(smp_rec),
    .state(state), .level(level), .drop_cnt(drop_cnt)
  );

  axi_sample_ctrl #(.DW(32), .DEPTH(8), .CNTW(16), .STOP_ON_FULL(1'b1)) u_dut_sof (
    .clk(clk), .rst(rst), .sample_conf_ctrl(sample_conf_ctrl),
    .arm(arm), .stop(stop), .clear(clear),
    .awvalid(awvalid), .wvalid(wvalid), .arvalid(arvalid), .rvalid(rvalid),
    .awready(awready), .wready(wready), .arready(arready), .rready(rready),
    .awpayld(awpayld), .wpayld(wpayld), .arpayld(arpayld), .rpayld(rpayld),
    .awprot(awprot), .wprot(wprot), .arprot(arprot), .rprot(rprot),
    .smp_valid(sof_smp_valid), .smp_ready(smp_ready), .smp_rec(sof_smp_rec),
    .state(sof_state), .level(sof_level), .drop_cnt(sof_drop_cnt)
  );

  // Scoreboard: every popped record must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && smp_valid && smp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got rec=%h, required no record", smp_rec);
      end else begin
        mon_exp = sb.pop_front();
        if (smp_rec !== mon_exp) begin
          failures++;
          $display("FAIL sb_record: got rec=%h, required %h", smp_rec, mon_exp);
        end
      end
    end
  end

  function automatic logic [35:0] mk_rec(input logic [1:0] ch, input logic [2:0] prot,
                                         input logic [31:0] d);
    return {ch, prot[0], prot[2], d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    {awvalid, wvalid, arvalid, rvalid} = '0;
    {awready, wready, arready, rready} = '0;
  endtask

  task automatic beat(input int ch, input logic [2:0] prot, input logic [31:0] d);
    case (ch)
      0: begin awvalid = 1'b1; awready = 1'b1; awprot = prot; awpayld = d; end
      1: begin wvalid  = 1'b1; wready  = 1'b1; wprot  = prot; wpayld  = d; end
      2: begin arvalid = 1'b1; arready = 1'b1; arprot = prot; arpayld = d; end
      default: begin rvalid = 1'b1; rready = 1'b1; rprot = prot; rpayld = d; end
    endcase
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin tick(); n++; end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d records outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    checks++;
    if (state !== 2'b00 || smp_valid !== 1'b0 || smp_rec !== 36'h0 || level !== 4'd0 ||
        drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_values: got st=%b v=%b rec=%h lvl=%0d drop=%0d, required 0s",
               state, smp_valid, smp_rec, level, drop_cnt);
    end
  endtask

  task automatic test_basic_latency();
    logic [35:0] exp;
    sample_conf_ctrl = 16'h8000; smp_ready = 1'b0;
    do_arm();
    checks++;
    if (state !== 2'b01) begin
      failures++; $display("FAIL arm_run: got state=%b, required 01", state);
    end
    exp = mk_rec(2'd0, 3'b000, 32'h10);
    beat(0, 3'b000, 32'h10); sb.push_back(exp); tick(); quiet();
    checks++;
    if (smp_valid !== 1'b0) begin
      failures++; $display("FAIL lat_n1: got smp_valid=%b, required 0", smp_valid);
    end
    tick();
    checks++;
    if (smp_valid !== 1'b1 || smp_rec !== exp || level !== 4'd1 || drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL lat_n2: got v=%b rec=%h lvl=%0d drop=%0d, required 1 %h 1 0",
               smp_valid, smp_rec, level, drop_cnt, exp);
    end
    smp_ready = 1'b1;
    wait_drain(10);
    beat(0, 3'b001, 32'h20); tick(); quiet(); tick(); tick();
    beat(0, 3'b000, 32'h30); awready = 1'b0; tick(); quiet(); tick(); tick();
    checks++;
    if (level !== 4'd0 || smp_valid !== 1'b0) begin
      failures++;
      $display("FAIL filter_aw: got lvl=%0d v=%b, required 0 0", level, smp_valid);
    end
  endtask

  task automatic test_rdata_sel();
    sample_conf_ctrl = 16'h0001; smp_ready = 1'b1;
    beat(3, 3'b101, 32'hAB); sb.push_back(mk_rec(2'd3, 3'b101, 32'hAB)); tick(); quiet();
    wait_drain(10);
    beat(3, 3'b000, 32'hAB); tick(); quiet(); tick(); tick();
    checks++;
    if (smp_valid !== 1'b0 || level !== 4'd0) begin
      failures++;
      $display("FAIL rdata_filtered: got v=%b lvl=%0d, required 0 0", smp_valid, level);
    end
  endtask

  task automatic test_all_four();
    do_clear();
    sample_conf_ctrl = 16'hFFFF; smp_ready = 1'b1;
    do_arm();
    beat(0, 3'b000, 32'hA0); beat(1, 3'b001, 32'hA1);
    beat(2, 3'b100, 32'hA2); beat(3, 3'b101, 32'hA3);
    sb.push_back(mk_rec(2'd0, 3'b000, 32'hA0)); sb.push_back(mk_rec(2'd1, 3'b001, 32'hA1));
    sb.push_back(mk_rec(2'd2, 3'b100, 32'hA2)); sb.push_back(mk_rec(2'd3, 3'b101, 32'hA3));
    tick(); quiet();
    wait_drain(20);
    checks++;
    if (drop_cnt !== 16'd0) begin
      failures++; $display("FAIL all_four_drop: got drop=%0d, required 0", drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    sample_conf_ctrl = 16'hFFFF; smp_ready = 1'b1;
    do_arm();
    sb.push_back(mk_rec(2'd0, 3'b000, 32'hB0)); sb.push_back(mk_rec(2'd3, 3'b000, 32'hC0));
    sb.push_back(mk_rec(2'd0, 3'b000, 32'hB1)); sb.push_back(mk_rec(2'd3, 3'b000, 32'hC2));
    for (int k = 0; k < 3; k++) begin
      beat(0, 3'b000, 32'hB0 + k); beat(3, 3'b000, 32'hC0 + k); tick();
    end
    quiet();
    wait_drain(20);
    checks++;
    if (drop_cnt !== 16'd2) begin
      failures++; $display("FAIL b2b_drop: got drop=%0d, required 2", drop_cnt);
    end
  endtask

  task automatic test_fill();
    do_clear();
    sample_conf_ctrl = 16'h8000; smp_ready = 1'b0;
    do_arm();
    for (int i = 0; i < 14; i++) begin
      beat(0, 3'b000, 32'(i));
      if (i < 9) sb.push_back(mk_rec(2'd0, 3'b000, 32'(i)));
      tick();
    end
    quiet();
    checks++;
    if (level !== 4'd8 || drop_cnt !== 16'd5 || state !== 2'b01) begin
      failures++;
      $display("FAIL fill: got lvl=%0d drop=%0d st=%b, required 8 5 01", level, drop_cnt, state);
    end
    checks++;
    if (sof_state !== 2'b10 || sof_drop_cnt !== 16'd1 || sof_level !== 4'd8) begin
      failures++;
      $display("FAIL stop_on_full: got st=%b drop=%0d lvl=%0d, required 10 1 8",
               sof_state, sof_drop_cnt, sof_level);
    end
    smp_ready = 1'b1;
    wait_drain(40);
    checks++;
    if (level !== 4'd0 || drop_cnt !== 16'd5 || sof_state !== 2'b00) begin
      failures++;
      $display("FAIL fill_drained: got lvl=%0d drop=%0d sof_st=%b, required 0 5 00",
               level, drop_cnt, sof_state);
    end
  endtask

  task automatic test_stop_drain();
    int n;
    do_clear();
    sample_conf_ctrl = 16'hFFFF; smp_ready = 1'b0;
    do_arm();
    beat(0, 3'b000, 32'hD0); beat(1, 3'b000, 32'hD1); beat(2, 3'b000, 32'hD2);
    sb.push_back(mk_rec(2'd0, 3'b000, 32'hD0)); sb.push_back(mk_rec(2'd1, 3'b000, 32'hD1));
    sb.push_back(mk_rec(2'd2, 3'b000, 32'hD2));
    tick(); quiet();
    stop = 1'b1; tick(); stop = 1'b0;
    checks++;
    if (state !== 2'b10) begin
      failures++; $display("FAIL stop_drain: got state=%b, required 10", state);
    end
    beat(3, 3'b000, 32'hD3); arm = 1'b1; tick(); quiet(); arm = 1'b0;
    checks++;
    if (state !== 2'b10) begin
      failures++; $display("FAIL drain_arm_ignored: got state=%b, required 10", state);
    end
    n = 0;
    while (state !== 2'b00 && n < 10) begin tick(); n++; end
    checks++;
    if (state !== 2'b00 || level !== 4'd3) begin
      failures++;
      $display("FAIL drain_idle: got st=%b lvl=%0d, required 00 3", state, level);
    end
    beat(0, 3'b000, 32'hD4); tick(); quiet(); tick(); tick();
    arm = 1'b1; stop = 1'b1; tick(); arm = 1'b0; stop = 1'b0;
    checks++;
    if (state !== 2'b00 || level !== 4'd3) begin
      failures++;
      $display("FAIL idle_arm_stop: got st=%b lvl=%0d, required 00 3", state, level);
    end
    smp_ready = 1'b1;
    wait_drain(20);
  endtask

  task automatic test_clear();
    sample_conf_ctrl = 16'hFFFF; smp_ready = 1'b0;
    do_arm();
    for (int k = 0; k < 4; k++) begin
      beat(0, 3'b000, 32'hE0 + k); beat(1, 3'b000, 32'hF0 + k); tick();
    end
    quiet(); tick(); tick(); tick();
    checks++;
    if (level !== 4'd5 || drop_cnt !== 16'd3) begin
      failures++;
      $display("FAIL pre_clear: got lvl=%0d drop=%0d, required 5 3", level, drop_cnt);
    end
    do_clear();
    checks++;
    if (level !== 4'd0 || smp_valid !== 1'b0 || drop_cnt !== 16'd0 || state !== 2'b00 ||
        smp_rec !== 36'h0) begin
      failures++;
      $display("FAIL clear: got lvl=%0d v=%b drop=%0d st=%b rec=%h, required all 0",
               level, smp_valid, drop_cnt, state, smp_rec);
    end
    // Pointer was left past waddr; after clear waddr must win again.
    do_arm();
    smp_ready = 1'b1;
    beat(0, 3'b000, 32'h11); beat(3, 3'b000, 32'h33);
    sb.push_back(mk_rec(2'd0, 3'b000, 32'h11)); sb.push_back(mk_rec(2'd3, 3'b000, 32'h33));
    tick(); quiet();
    wait_drain(20);
  endtask

  task automatic test_rst_mid();
    sample_conf_ctrl = 16'hFFFF; smp_ready = 1'b0;
    do_arm();
    for (int k = 0; k < 3; k++) begin beat(0, 3'b000, 32'h70 + k); tick(); end
    quiet();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (state !== 2'b00 || level !== 4'd0 || smp_valid !== 1'b0 || smp_rec !== 36'h0 ||
        drop_cnt !== 16'd0 || sof_state !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid: got st=%b lvl=%0d v=%b rec=%h drop=%0d, required all 0",
               state, level, smp_valid, smp_rec, drop_cnt);
    end
    tick(); tick();
    checks++;
    if (level !== 4'd0) begin
      failures++; $display("FAIL rst_inflight: got lvl=%0d, required 0", level);
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; stop = 1'b0; clear = 1'b0; smp_ready = 1'b0;
    sample_conf_ctrl = 16'h0000;
    awpayld = '0; wpayld = '0; arpayld = '0; rpayld = '0;
    awprot = '0; wprot = '0; arprot = '0; rprot = '0;
    quiet();
    tick(); tick(); tick();
    rst = 1'b0;
    test_reset();
    test_basic_latency();
    test_rdata_sel();
    test_all_four();
    test_back_to_back();
    test_fill();
    test_stop_drain();
    test_clear();
    test_rst_mid();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
